// File: rtl/uart_alim_tamponu_if.sv
// Consumer-side byte handshake of the UART receive buffer.
// The buffer drives the master modport and the bus peripheral drives the slave modport.
interface uart_alim_tamponu_if;
  logic [7:0] veri_o;
  logic       veri_gecerli_o;
  logic       veri_hazir_i;

  modport master (
    output veri_o,
    output veri_gecerli_o,
    input  veri_hazir_i
  );

  modport slave (
    input  veri_o,
    input  veri_gecerli_o,
    output veri_hazir_i
  );
endinterface

// File: rtl/uart_alim_tamponu.sv
// Receive-side FWFT byte buffer behind the UART receiver.
// Reports fill level, a sticky overrun flag, and a threshold/idle-timeout interrupt.
module uart_alim_tamponu #(
  parameter int unsigned DERINLIK    = 16,
  parameter int unsigned ESIK        = 8,
  parameter int unsigned ZAMAN_ASIMI = 4000
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [7:0]                alinan_veri_i,
  input  logic                      alinan_gecerli_i,
  uart_alim_tamponu_if.master       okuma,
  output logic [$clog2(DERINLIK):0] doluluk_o,
  output logic                      bos_o,
  output logic                      dolu_o,
  output logic                      tasma_o,
  input  logic                      tasma_temizle_i,
  output logic                      kesme_o
);

  localparam int unsigned AW = $clog2(DERINLIK);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = 16;

  localparam logic [CW-1:0] COUNT_FULL = CW'(DERINLIK);
  localparam logic [CW-1:0] COUNT_ESIK = CW'(ESIK);
  localparam logic [TW-1:0] TMR_LIMIT  = TW'(ZAMAN_ASIMI);
  localparam logic [TW-1:0] TMR_MAX    = '1;

  logic [7:0]    mem [DERINLIK];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic [TW-1:0] tmr_q,    tmr_d;
  logic          tmo_q,    tmo_d;
  logic          tasma_q,  tasma_d;

  logic          empty;
  logic          full;
  logic          rd_en;
  logic          wr_en;
  logic          drop;

  // Status decoded only from registered state.
  assign empty = (count_q == '0);
  assign full  = (count_q == COUNT_FULL);

  assign rd_en = !empty && okuma.veri_hazir_i;
  assign wr_en = alinan_gecerli_i && (!full || rd_en);
  assign drop  = alinan_gecerli_i && full && !rd_en;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    tasma_d  = tasma_q;
    tmr_d    = tmr_q;
    tmo_d    = tmo_q;

    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    unique case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Set wins over a same-cycle clear.
    if (tasma_temizle_i) begin
      tasma_d = 1'b0;
    end
    if (drop) begin
      tasma_d = 1'b1;
    end

    // Idle timer restarts on any traffic and sits at zero while empty.
    if (wr_en || rd_en || (count_d == '0)) begin
      tmr_d = '0;
      tmo_d = 1'b0;
    end else if (tmr_q != TMR_MAX) begin
      tmr_d = tmr_q + TW'(1);
    end

    if (tmr_d >= TMR_LIMIT) begin
      tmo_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      tasma_q  <= 1'b0;
      tmr_q    <= '0;
      tmo_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      tasma_q  <= tasma_d;
      tmr_q    <= tmr_d;
      tmo_q    <= tmo_d;
    end
  end

  // Storage array carries no reset; stale contents are masked by the count.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= alinan_veri_i;
    end
  end

  assign okuma.veri_o         = empty ? 8'h00 : mem[rd_ptr_q];
  assign okuma.veri_gecerli_o = !empty;
  assign doluluk_o            = count_q;
  assign bos_o                = empty;
  assign dolu_o               = full;
  assign tasma_o              = tasma_q;
  assign kesme_o              = (count_q >= COUNT_ESIK) || tmo_q;

endmodule

// File: tb/tb_uart_alim_tamponu.sv
// Self-checking bench for uart_alim_tamponu: directed scenarios plus random
// streaming, compared every cycle against a queue-based reference model.
module tb_uart_alim_tamponu;

  localparam int unsigned DERINLIK    = 16;
  localparam int unsigned ESIK        = 8;
  localparam int unsigned ZAMAN_ASIMI = 4000;
  localparam int unsigned CW          = $clog2(DERINLIK) + 1;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic [7:0]    alinan_veri_i = 8'h00;
  logic          alinan_gecerli_i = 1'b0;
  logic [CW-1:0] doluluk_o;
  logic          bos_o;
  logic          dolu_o;
  logic          tasma_o;
  logic          tasma_temizle_i = 1'b0;
  logic          kesme_o;

  uart_alim_tamponu_if bus ();

  uart_alim_tamponu #(
    .DERINLIK    (DERINLIK),
    .ESIK        (ESIK),
    .ZAMAN_ASIMI (ZAMAN_ASIMI)
  ) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .alinan_veri_i    (alinan_veri_i),
    .alinan_gecerli_i (alinan_gecerli_i),
    .okuma            (bus.master),
    .doluluk_o        (doluluk_o),
    .bos_o            (bos_o),
    .dolu_o           (dolu_o),
    .tasma_o          (tasma_o),
    .tasma_temizle_i  (tasma_temizle_i),
    .kesme_o          (kesme_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: byte queue, sticky overrun, cycles idle while non-empty.
  logic [7:0] m_q [$];
  logic       m_tasma = 1'b0;
  int         m_idle  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic chk_all();
    chk("veri",    32'(bus.veri_o),         32'(m_q.size() != 0 ? m_q[0] : 8'h00));
    chk("gecerli", 32'(bus.veri_gecerli_o), 32'(m_q.size() != 0));
    chk("doluluk", 32'(doluluk_o),          32'(m_q.size()));
    chk("bos",     32'(bos_o),              32'(m_q.size() == 0));
    chk("dolu",    32'(dolu_o),             32'(m_q.size() == DERINLIK));
    chk("tasma",   32'(tasma_o),            32'(m_tasma));
    chk("kesme",   32'(kesme_o),            32'((m_q.size() >= ESIK) || (m_idle >= int'(ZAMAN_ASIMI))));
  endtask

  // Apply one cycle of inputs, advance the model at the edge, check after it.
  task automatic step(input logic g, input logic [7:0] d, input logic h, input logic t);
    bit rd, wr;
    alinan_gecerli_i = g;
    alinan_veri_i    = d;
    bus.veri_hazir_i = h;
    tasma_temizle_i  = t;
    @(posedge clk_i);
    rd = (m_q.size() != 0) && h;
    wr = g && ((m_q.size() < DERINLIK) || rd);
    if (rd) void'(m_q.pop_front());
    if (wr) m_q.push_back(d);
    if (g && !wr)  m_tasma = 1'b1;
    else if (t)    m_tasma = 1'b0;
    if (wr || rd || m_q.size() == 0) m_idle = 0;
    else                             m_idle++;
    #1;
    chk_all();
  endtask

  task automatic idle_inputs();
    alinan_gecerli_i = 1'b0;
    alinan_veri_i    = 8'h00;
    bus.veri_hazir_i = 1'b0;
    tasma_temizle_i  = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 4 * DERINLIK && m_q.size() != 0; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("drain_empty", 32'(bos_o), 32'd1);
  endtask

  initial begin
    logic [7:0] seq [3];
    int first_k;
    int sent;

    idle_inputs();
    #2;
    chk_all();
    chk("rst_bos", 32'(bos_o), 32'd1);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Ordered write then read.
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    step(1'b1, 8'h3C, 1'b0, 1'b0);
    step(1'b1, 8'h7E, 1'b0, 1'b0);
    chk("t1_count", 32'(doluluk_o), 32'd3);
    chk("t1_head",  32'(bus.veri_o), 32'hA5);
    seq[0] = 8'hA5; seq[1] = 8'h3C; seq[2] = 8'h7E;
    for (int i = 0; i < 3; i++) begin
      chk("t1_order", 32'(bus.veri_o), 32'(seq[i]));
      step(1'b0, 8'h00, 1'b1, 1'b0);
    end
    chk("t1_empty", 32'(bos_o), 32'd1);
    chk("t1_zero",  32'(bus.veri_o), 32'h00);

    // Fill, overrun, drain, clear.
    for (int i = 0; i < DERINLIK; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    step(1'b1, 8'hFF, 1'b0, 1'b0);
    chk("t2_dolu",  32'(dolu_o), 32'd1);
    chk("t2_tasma", 32'(tasma_o), 32'd1);
    for (int i = 0; i < DERINLIK; i++) begin
      chk("t2_order", 32'(bus.veri_o), 32'(i));
      step(1'b0, 8'h00, 1'b1, 1'b0);
    end
    chk("t2_empty", 32'(bos_o), 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("t2_clear", 32'(tasma_o), 32'd0);

    // Full plus same-cycle read and write: no overrun.
    for (int i = 0; i < DERINLIK; i++) step(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
    step(1'b1, 8'h55, 1'b1, 1'b0);
    chk("t3_tasma", 32'(tasma_o), 32'd0);
    chk("t3_count", 32'(doluluk_o), 32'(DERINLIK));
    for (int i = 1; i < DERINLIK; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t3_last", 32'(bus.veri_o), 32'h55);
    drain();

    // Threshold.
    for (int i = 0; i < ESIK - 1; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
    chk("t4_below", 32'(kesme_o), 32'd0);
    step(1'b1, 8'($urandom), 1'b0, 1'b0);
    chk("t4_at", 32'(kesme_o), 32'd1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t4_read", 32'(kesme_o), 32'd0);
    drain();

    // Idle timeout latency.
    step(1'b1, 8'h42, 1'b0, 1'b0);
    first_k = 0;
    for (int k = 1; k <= int'(ZAMAN_ASIMI) + 10; k++) begin
      step(1'b0, 8'h00, 1'b0, 1'b0);
      if (kesme_o && first_k == 0) first_k = k;
    end
    chk("t5_latency", 32'(first_k), 32'(ZAMAN_ASIMI));
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t5_clear", 32'(kesme_o), 32'd0);

    // Random streaming across pointer wrap.
    sent = 0;
    for (int c = 0; c < 2000 && sent < 3 * DERINLIK; c++) begin
      logic g;
      g = 1'($urandom_range(0, 1));
      if (g) sent++;
      step(g, 8'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
    end
    chk("t6_sent", 32'(sent), 32'(3 * DERINLIK));
    drain();

    // Asynchronous reset with data buffered.
    for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
    chk("t6_pre", 32'(doluluk_o), 32'd5);
    #2;
    rst_i = 1'b1;
    #1;
    m_q.delete();
    m_tasma = 1'b0;
    m_idle  = 0;
    chk_all();
    chk("t6_rst_veri", 32'(bus.veri_o), 32'h00);
    idle_inputs();
    @(negedge clk_i);
    rst_i = 1'b0;
    step(1'b0, 8'h00, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
